store_scoreboard: RTL and testbench

Synthesisable store-stream checker that replaces hand-written pass/fail logic in per-instruction processor benches. It attaches to the `top` store bus (`memwrite`, `dataadr`, `writedata`) and is loaded with up to DEPTH expected (address, data) stores and up to NIGN ignored scratch addresses. It checks stores in ordered or unordered mode, with a watchdog timeout, and reports sticky pass/fail plus a failure cause and entry index.

---
 rtl/store_scoreboard.sv | 203 ++++++++++++++++++++
 tb/tb_store_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_scoreboard.sv
// Store-stream checker: compares a processor's store bus against a loaded table of
// expected (address, data) stores, with ignorable scratch addresses and a watchdog.
module store_scoreboard #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NIGN    = 4,
    parameter bit          ORDERED = 1'b1,
    parameter int unsigned TIMEOUT = 1000,
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             exp_push,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             ign_push,
    input  logic [WIDTH-1:0] ign_addr,
    input  logic             clear,
    input  logic             start,
    output logic             armed,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [IW-1:0]    fail_idx,
    output logic [CW-1:0]    match_cnt
);

    localparam int unsigned GW = $clog2(NIGN + 1);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [GW-1:0] NignC  = GW'(NIGN);
    localparam logic [TW-1:0] TLimit = TW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StArmed, StPass, StFail} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] exp_addr_q [DEPTH];
    logic [WIDTH-1:0] exp_data_q [DEPTH];
    logic [WIDTH-1:0] ign_addr_q [NIGN];
    logic [CW-1:0]    exp_cnt_q;
    logic [GW-1:0]    ign_cnt_q;
    logic [DEPTH-1:0] consumed_q;
    logic [TW-1:0]    timer_q;

    logic             loading, exp_wr, ign_wr;
    logic [WIDTH-1:0] ord_addr, ord_data;
    logic             any_full, any_addr, ign_hit;
    logic [IW-1:0]    full_idx, addr_idx, hit_idx;
    logic             hit, bad_data, bad_addr;
    logic [TW-1:0]    timer_inc;
    logic             timeout_hit;

    // Loads only land when no higher-priority control is active and the checker is idle.
    assign loading = !reset && (state_q != StArmed) && !clear && !start;
    assign exp_wr  = loading && exp_push && (exp_cnt_q != DepthC);
    assign ign_wr  = loading && ign_push && (ign_cnt_q != NignC);

    assign timer_inc   = (timer_q == TLimit) ? timer_q : timer_q + TW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (timer_inc == TLimit);

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (exp_wr && (exp_cnt_q == CW'(i))) begin
                exp_addr_q[i] <= exp_addr;
                exp_data_q[i] <= exp_data;
            end
        end
        for (int i = 0; i < int'(NIGN); i++) begin
            if (ign_wr && (ign_cnt_q == GW'(i))) begin
                ign_addr_q[i] <= ign_addr;
            end
        end
    end

    always_comb begin
        ord_addr = '0;
        ord_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (match_cnt == CW'(i)) begin
                ord_addr = exp_addr_q[i];
                ord_data = exp_data_q[i];
            end
        end

        // Scan downwards so the lowest matching index is the one left standing.
        any_full = 1'b0;
        any_addr = 1'b0;
        full_idx = '0;
        addr_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if ((CW'(i) < exp_cnt_q) && !consumed_q[i] && (exp_addr_q[i] == dataadr)) begin
                any_addr = 1'b1;
                addr_idx = IW'(i);
                if (exp_data_q[i] == writedata) begin
                    any_full = 1'b1;
                    full_idx = IW'(i);
                end
            end
        end

        ign_hit = 1'b0;
        for (int i = 0; i < int'(NIGN); i++) begin
            if ((GW'(i) < ign_cnt_q) && (ign_addr_q[i] == dataadr)) begin
                ign_hit = 1'b1;
            end
        end

        hit      = 1'b0;
        bad_data = 1'b0;
        bad_addr = 1'b0;
        hit_idx  = '0;
        if (ORDERED) begin
            if (ord_addr == dataadr) begin
                hit      = (ord_data == writedata);
                bad_data = !hit;
                hit_idx  = IW'(match_cnt);
            end else begin
                bad_addr = !ign_hit;
            end
        end else begin
            if (any_full) begin
                hit     = 1'b1;
                hit_idx = full_idx;
            end else if (any_addr) begin
                bad_data = 1'b1;
                hit_idx  = addr_idx;
            end else begin
                bad_addr = !ign_hit;
            end
        end
        if (!memwrite) begin
            hit      = 1'b0;
            bad_data = 1'b0;
            bad_addr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            exp_cnt_q  <= '0;
            ign_cnt_q  <= '0;
            consumed_q <= '0;
            match_cnt  <= '0;
            fail_code  <= 2'd0;
            fail_idx   <= '0;
            timer_q    <= '0;
        end else if (state_q == StArmed) begin
            // A store outcome on this edge takes precedence over the watchdog.
            if (exp_cnt_q == '0) begin
                state_q <= StPass;
            end else if (hit) begin
                consumed_q[hit_idx] <= 1'b1;
                match_cnt           <= match_cnt + CW'(1);
                timer_q             <= '0;
                if (match_cnt + CW'(1) == exp_cnt_q) begin
                    state_q <= StPass;
                end
            end else if (bad_data) begin
                state_q   <= StFail;
                fail_code <= 2'd1;
                fail_idx  <= hit_idx;
            end else if (bad_addr) begin
                state_q   <= StFail;
                fail_code <= 2'd2;
            end else begin
                timer_q <= timer_inc;
                if (timeout_hit) begin
                    state_q   <= StFail;
                    fail_code <= 2'd3;
                end
            end
        end else if (clear) begin
            exp_cnt_q <= '0;
            ign_cnt_q <= '0;
        end else if (start) begin
            state_q    <= StArmed;
            consumed_q <= '0;
            match_cnt  <= '0;
            fail_code  <= 2'd0;
            fail_idx   <= '0;
            timer_q    <= '0;
        end else begin
            if (exp_wr) begin
                exp_cnt_q <= exp_cnt_q + CW'(1);
            end
            if (ign_wr) begin
                ign_cnt_q <= ign_cnt_q + GW'(1);
            end
        end
    end

    assign armed = (state_q == StArmed);
    assign pass  = (state_q == StPass);
    assign fail  = (state_q == StFail);
    assign done  = pass || fail;

endmodule

// File: tb/tb_store_scoreboard.sv
// Bench for store_scoreboard: an ordered and an unordered instance share stimulus and are
// checked every cycle against a table-driven model, plus directed literal scenarios.
module tb_store_scoreboard;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned NI = 2;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset, memwrite, exp_push, ign_push, clear, start;
    logic [W-1:0]  dataadr, writedata, exp_addr, exp_data, ign_addr;

    logic [1:0]    d_armed, d_done, d_pass, d_fail;
    logic [1:0]    d_code [2];
    logic [1:0]    d_idx  [2];
    logic [2:0]    d_mcnt [2];

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 armed, 2 pass, 3 fail
    int       m_st [2], m_ecnt [2], m_icnt [2], m_mcnt [2], m_timer [2], m_code [2], m_idx [2];
    logic [31:0] m_ea [2][D];
    logic [31:0] m_ed [2][D];
    logic [31:0] m_ia [2][NI];
    bit       m_used [2][D];

    store_scoreboard #(.WIDTH(W), .DEPTH(D), .NIGN(NI), .ORDERED(1'b1), .TIMEOUT(TO)) u_ord (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_push(exp_push), .exp_addr(exp_addr),
        .exp_data(exp_data), .ign_push(ign_push), .ign_addr(ign_addr), .clear(clear),
        .start(start), .armed(d_armed[0]), .done(d_done[0]), .pass(d_pass[0]),
        .fail(d_fail[0]), .fail_code(d_code[0]), .fail_idx(d_idx[0]), .match_cnt(d_mcnt[0])
    );

    store_scoreboard #(.WIDTH(W), .DEPTH(D), .NIGN(NI), .ORDERED(1'b0), .TIMEOUT(TO)) u_unord (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_push(exp_push), .exp_addr(exp_addr),
        .exp_data(exp_data), .ign_push(ign_push), .ign_addr(ign_addr), .clear(clear),
        .start(start), .armed(d_armed[1]), .done(d_done[1]), .pass(d_pass[1]),
        .fail(d_fail[1]), .fail_code(d_code[1]), .fail_idx(d_idx[1]), .match_cnt(d_mcnt[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int m, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h expected %0h at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic strobes_off();
        reset = 0; memwrite = 0; exp_push = 0; ign_push = 0; clear = 0; start = 0;
    endtask

    // Apply the rules to one instance for the inputs present at this edge.
    task automatic step(input int m);
        int outcome;
        int idx;
        int first_addr;
        int first_full;
        if (reset) begin
            m_st[m] = 0; m_ecnt[m] = 0; m_icnt[m] = 0; m_mcnt[m] = 0;
            m_timer[m] = 0; m_code[m] = 0; m_idx[m] = 0;
            return;
        end
        if (m_st[m] != 1) begin
            if (clear) begin
                m_ecnt[m] = 0;
                m_icnt[m] = 0;
            end else if (start) begin
                m_st[m] = 1; m_mcnt[m] = 0; m_code[m] = 0; m_idx[m] = 0; m_timer[m] = 0;
                for (int i = 0; i < int'(D); i++) m_used[m][i] = 0;
            end else begin
                if (exp_push && m_ecnt[m] < int'(D)) begin
                    m_ea[m][m_ecnt[m]] = exp_addr;
                    m_ed[m][m_ecnt[m]] = exp_data;
                    m_ecnt[m]++;
                end
                if (ign_push && m_icnt[m] < int'(NI)) begin
                    m_ia[m][m_icnt[m]] = ign_addr;
                    m_icnt[m]++;
                end
            end
            return;
        end
        if (m_ecnt[m] == 0) begin
            m_st[m] = 2;
            return;
        end
        outcome = 0;  // 0 nothing, 1 consume, 2 data fail, 3 address fail
        idx = 0;
        if (memwrite) begin
            outcome = 3;
            if (m == 0) begin
                if (dataadr == m_ea[m][m_mcnt[m]]) begin
                    outcome = (writedata == m_ed[m][m_mcnt[m]]) ? 1 : 2;
                    idx = m_mcnt[m];
                end
            end else begin
                first_addr = -1;
                first_full = -1;
                for (int i = 0; i < m_ecnt[m]; i++) begin
                    if (!m_used[m][i] && m_ea[m][i] == dataadr) begin
                        if (first_addr < 0) first_addr = i;
                        if (first_full < 0 && m_ed[m][i] == writedata) first_full = i;
                    end
                end
                if (first_full >= 0) begin
                    outcome = 1; idx = first_full;
                end else if (first_addr >= 0) begin
                    outcome = 2; idx = first_addr;
                end
            end
            if (outcome == 3) begin
                for (int i = 0; i < m_icnt[m]; i++) if (m_ia[m][i] == dataadr) outcome = 0;
            end
        end
        case (outcome)
            1: begin
                m_used[m][idx] = 1;
                m_mcnt[m]++;
                m_timer[m] = 0;
                if (m_mcnt[m] == m_ecnt[m]) m_st[m] = 2;
            end
            2: begin m_st[m] = 3; m_code[m] = 1; m_idx[m] = idx; end
            3: begin m_st[m] = 3; m_code[m] = 2; end
            default: begin
                m_timer[m]++;
                if (m_timer[m] == int'(TO)) begin m_st[m] = 3; m_code[m] = 3; end
            end
        endcase
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            chk("armed", m, d_armed[m], m_st[m] == 1);
            chk("done", m, d_done[m], m_st[m] >= 2);
            chk("pass", m, d_pass[m], m_st[m] == 2);
            chk("fail", m, d_fail[m], m_st[m] == 3);
            chk("fail_code", m, d_code[m], m_code[m]);
            chk("fail_idx", m, d_idx[m], m_idx[m]);
            chk("match_cnt", m, d_mcnt[m], m_mcnt[m]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step(0);
        step(1);
        #1;
        compare_all();
        strobes_off();
    endtask

    task automatic expect_st(input int m, input int a, input int p, input int f, input int code,
                             input int idx, input int mc);
        chk("lit_armed", m, d_armed[m], a);
        chk("lit_pass", m, d_pass[m], p);
        chk("lit_fail", m, d_fail[m], f);
        chk("lit_done", m, d_done[m], p | f);
        chk("lit_code", m, d_code[m], code);
        chk("lit_idx", m, d_idx[m], idx);
        chk("lit_mcnt", m, d_mcnt[m], mc);
    endtask

    task automatic expect_both(input int a, input int p, input int f, input int code,
                               input int idx, input int mc);
        expect_st(0, a, p, f, code, idx, mc);
        expect_st(1, a, p, f, code, idx, mc);
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_push = 1; exp_addr = a; exp_data = d;
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        tick();
    endtask

    task automatic do_start();
        start = 1;
        tick();
    endtask

    initial begin
        strobes_off();
        dataadr = 0; writedata = 0; exp_addr = 0; exp_data = 0; ign_addr = 0;

        do_reset();
        expect_both(0, 0, 0, 0, 0, 0);

        // Ordered pass through an ignored scratch store
        exp_push = 1; exp_addr = 84; exp_data = 32'hFFFF7F02;
        ign_push = 1; ign_addr = 80;
        tick();
        do_start();
        expect_both(1, 0, 0, 0, 0, 0);
        store(80, 32'h7);
        expect_both(1, 0, 0, 0, 0, 0);
        store(84, 32'hFFFF7F02);
        expect_both(0, 1, 0, 0, 0, 1);

        // Data mismatch, then re-arm with tables kept
        do_start();
        store(84, 32'h12);
        expect_both(0, 0, 1, 1, 0, 0);
        do_start();
        expect_both(1, 0, 0, 0, 0, 0);
        store(84, 32'hFFFF7F02);
        expect_both(0, 1, 0, 0, 0, 1);

        // Out-of-order stream: ordered rejects, unordered accepts
        do_reset();
        push_exp(84, 5);
        push_exp(88, 6);
        do_start();
        store(88, 6);
        expect_st(0, 0, 0, 1, 2, 0, 0);
        expect_st(1, 1, 0, 0, 0, 0, 1);
        store(84, 5);
        expect_st(0, 0, 0, 1, 2, 0, 0);
        expect_st(1, 0, 1, 0, 0, 0, 2);

        // Watchdog: fail exactly TO edges after arming; a match on that edge wins
        do_reset();
        push_exp(84, 5);
        do_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_both(1, 0, 0, 0, 0, 0);
        end
        tick();
        expect_both(0, 0, 1, 3, 0, 0);
        do_start();
        for (int i = 0; i < 3; i++) tick();
        store(84, 5);
        expect_both(0, 1, 0, 0, 0, 1);

        // Table overflow keeps only the first DEPTH entries
        do_reset();
        for (int i = 0; i <= int'(D); i++) push_exp(32'(100 + 4 * i), 32'(i));
        do_start();
        for (int i = 0; i < int'(D); i++) store(32'(100 + 4 * i), 32'(i));
        expect_both(0, 1, 0, 0, 0, 4);

        // Push while armed is dropped
        do_reset();
        push_exp(84, 5);
        do_start();
        push_exp(88, 6);
        store(84, 5);
        expect_both(0, 1, 0, 0, 0, 1);

        // Empty table passes one edge after arming
        do_reset();
        do_start();
        expect_both(1, 0, 0, 0, 0, 0);
        tick();
        expect_both(0, 1, 0, 0, 0, 0);

        // Reset mid-run empties the tables
        do_reset();
        push_exp(84, 5);
        push_exp(88, 6);
        do_start();
        store(84, 5);
        expect_both(1, 0, 0, 0, 0, 1);
        do_reset();
        expect_both(0, 0, 0, 0, 0, 0);
        do_start();
        tick();
        expect_both(0, 1, 0, 0, 0, 0);

        // Clear empties tables outside ARMED
        push_exp(84, 5);
        clear = 1;
        tick();
        do_start();
        tick();
        expect_both(0, 1, 0, 0, 0, 0);

        // Randomised traffic from small address/data pools to provoke hits
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 14) == 0);
            exp_push = ($urandom_range(0, 3) == 0);
            ign_push = ($urandom_range(0, 5) == 0);
            memwrite = ($urandom_range(0, 3) != 0);
            exp_addr  = 32'h80 + 4 * $urandom_range(0, 5);
            exp_data  = ($urandom_range(0, 3) == 0) ? 32'hFFFF0000 | $urandom_range(0, 2)
                                                     : 32'($urandom_range(0, 2));
            ign_addr  = 32'h80 + 4 * $urandom_range(0, 5);
            dataadr   = 32'h80 + 4 * $urandom_range(0, 5);
            writedata = ($urandom_range(0, 3) == 0) ? 32'hFFFF0000 | $urandom_range(0, 2)
                                                     : 32'($urandom_range(0, 2));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
